aes_block_sequencer: RTL and testbench

//  Moves 128-bit blocks from the input block FIFO through the AES core and into the output block FIFO, one block at a time.

---
 rtl/aes_seq_pkg.sv | 32 +++
 rtl/aes_block_sequencer_if.sv | 30 +++
 rtl/seq_cycle_timer.sv | 32 +++
 rtl/aes_block_sequencer.sv | 148 ++++++++++++++
 tb/tb_aes_block_sequencer.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: shared types and constants for the AES block sequencer.
//   seq_state_e : 3-bit FSM encoding (IDLE, POP, WAIT_RD, LOAD, RUN, PUSH, GAP, ERR)
//   BLOCK_W     : AES block width (fixed at 128)
//   tmr_width() : bits needed for the shared down-counter, clog2(max(a,b,c))
//   TMR_W       : timer width for the default parameter set
package aes_seq_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    WAIT_RD = 3'd2,
    LOAD    = 3'd3,
    RUN     = 3'd4,
    PUSH    = 3'd5,
    GAP     = 3'd6,
    ERR     = 3'd7
  } seq_state_e;

  // The counter loads (value-1), so clog2(max) bits always suffice; keep >= 1 bit.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int TMR_W = tmr_width(3, 3, 1024);

endpackage

// File: rtl/aes_block_sequencer_if.sv
// aes_block_sequencer_if: FIFO and AES-core handshake bundle.
//   in_*  : input block FIFO (empty flag, data, pop strobe)
//   aes_* : AES core (start/din, done/dout)
//   out_* : output block FIFO (full flag, write strobe, data)
// Modports: master = sequencer side, slave = FIFOs/AES core side.
interface aes_block_sequencer_if;
  import aes_seq_pkg::*;

  logic               in_empty;
  logic [BLOCK_W-1:0] in_data;
  logic               in_rd_en;
  logic               aes_start;
  logic [BLOCK_W-1:0] aes_din;
  logic               aes_done;
  logic [BLOCK_W-1:0] aes_dout;
  logic               out_full;
  logic               out_wr_en;
  logic [BLOCK_W-1:0] out_data;

  modport master (
    input  in_empty, in_data, aes_done, aes_dout, out_full,
    output in_rd_en, aes_start, aes_din, out_wr_en, out_data
  );

  modport slave (
    output in_empty, in_data, aes_done, aes_dout, out_full,
    input  in_rd_en, aes_start, aes_din, out_wr_en, out_data
  );

endinterface

// File: rtl/seq_cycle_timer.sv
// seq_cycle_timer: loadable down-counter with zero flag.
//   clk, reset (async, active-low)
//   load/load_val : load a new count (wins over dec)
//   dec           : count down by one, saturating at zero
//   zero          : count is zero
module seq_cycle_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                  cnt_d = load_val;
    else if (dec && !zero)     cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/aes_block_sequencer.sv
// aes_block_sequencer: moves one 128-bit block at a time from the input FIFO
// through the AES core into the output FIFO.
//   clk, reset (async, active-low)
//   enable    : level, allows new blocks to start
//   bus       : FIFO/AES handshakes (aes_block_sequencer_if.master)
//   busy      : FSM not in IDLE
//   blk_count : blocks written to the output FIFO (wraps)
//   err       : sticky watchdog error, err_clr returns to IDLE
// Optional feature: define SEQ_WATCHDOG_EN to bound the wait for aes_done to
// AES_TIMEOUT cycles; without it RUN waits forever and err is tied low.
module aes_block_sequencer
  import aes_seq_pkg::*;
#(
  parameter int RD_LAT      = 3,
  parameter int WR_GAP      = 3,
  parameter int AES_TIMEOUT = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   err_clr,
  aes_block_sequencer_if.master  bus,
  output logic                   busy,
  output logic [CNT_W-1:0]       blk_count,
  output logic                   err
);

  localparam int            TW      = tmr_width(RD_LAT, WR_GAP, AES_TIMEOUT);
  localparam logic [TW-1:0] RD_LOAD = TW'(RD_LAT - 1);
  localparam logic [TW-1:0] WR_LOAD = TW'(WR_GAP - 1);
`ifdef SEQ_WATCHDOG_EN
  localparam logic [TW-1:0] WD_LOAD = TW'(AES_TIMEOUT - 1);
`endif

  seq_state_e         state_q, state_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [BLOCK_W-1:0] res_q, res_d;
  logic [CNT_W-1:0]   blk_count_q, blk_count_d;

  logic          tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic          rd_en, start, wr_en;

  // One timer serves WAIT_RD, GAP and the RUN watchdog; only one is ever active.
  seq_cycle_timer #(.W(TW)) u_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    res_d       = res_q;
    blk_count_d = blk_count_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_dec     = 1'b0;
    rd_en       = 1'b0;
    start       = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: if (enable && !bus.in_empty && !bus.out_full) state_d = POP;
      POP: begin
        rd_en    = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = RD_LOAD;
        state_d  = WAIT_RD;
      end
      WAIT_RD: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          data_d  = bus.in_data;
          state_d = LOAD;
        end
      end
      LOAD: begin
        start   = 1'b1;
`ifdef SEQ_WATCHDOG_EN
        tmr_load = 1'b1;
        tmr_val  = WD_LOAD;
`endif
        state_d = RUN;
      end
      RUN: begin
        // aes_done is only looked at here; pulses in any other state are dropped.
        if (bus.aes_done) begin
          res_d   = bus.aes_dout;
          state_d = PUSH;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (tmr_zero) state_d = ERR;
        else               tmr_dec = 1'b1;
`endif
      end
      PUSH: if (!bus.out_full) begin
        wr_en       = 1'b1;
        blk_count_d = blk_count_q + 1'b1;
        tmr_load    = 1'b1;
        tmr_val     = WR_LOAD;
        state_d     = GAP;
      end
      GAP: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_d = IDLE;
      end
`ifdef SEQ_WATCHDOG_EN
      ERR: if (err_clr) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      res_q       <= '0;
      blk_count_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      res_q       <= res_d;
      blk_count_q <= blk_count_d;
    end
  end

  assign bus.in_rd_en  = rd_en;
  assign bus.aes_start = start;
  assign bus.aes_din   = data_q;
  assign bus.out_wr_en = wr_en;
  assign bus.out_data  = res_q;
  assign busy          = (state_q != IDLE);
  assign blk_count     = blk_count_q;

`ifdef SEQ_WATCHDOG_EN
  assign err = (state_q == ERR);
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_block_sequencer.sv
module tb_aes_block_sequencer;
  import aes_seq_pkg::*;

  localparam int RD_LAT  = 3;
  localparam int WR_GAP  = 3;
  localparam int AES_LAT = 10;
  localparam int MIN_SEP = RD_LAT + WR_GAP + 13;
  localparam logic [127:0] GARBAGE = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, err_clr = 1'b0;
  logic        busy, err;
  logic [15:0] blk_count;
  logic        out_full = 1'b0, hang = 1'b0, spur = 1'b0;

  aes_block_sequencer_if bus();

  aes_block_sequencer #(
    .RD_LAT(RD_LAT), .WR_GAP(WR_GAP), .AES_TIMEOUT(16), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .err_clr(err_clr),
    .bus(bus), .busy(busy), .blk_count(blk_count), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- input FIFO model: data valid RD_LAT cycles after pop
  logic [127:0] mem [0:15];
  int           n_pushed = 0;
  int           rd_idx = 0;
  logic         rd_pend = 1'b0;
  int           rd_cnt = 0;
  logic [127:0] rd_hold = '0;

  always @(negedge clk) begin
    if (bus.in_rd_en) begin
      rd_hold <= mem[rd_idx];
      rd_idx  <= rd_idx + 1;
      rd_pend <= 1'b1;
      rd_cnt  <= RD_LAT;
    end else if (rd_pend) begin
      if (rd_cnt == 0) rd_pend <= 1'b0;
      else             rd_cnt  <= rd_cnt - 1;
    end
  end

  assign bus.in_empty = (rd_idx >= n_pushed);
  assign bus.in_data  = (rd_pend && rd_cnt == 0) ? rd_hold : GARBAGE;
  assign bus.out_full = out_full;

  // ---------------- AES model: done AES_LAT cycles after start, result = ~din
  logic [127:0] a_buf = '0;
  int           a_cnt = 0;
  logic         a_act = 1'b0;

  always @(negedge clk) begin
    if (bus.aes_start) begin
      a_buf <= ~bus.aes_din;
      a_cnt <= AES_LAT;
      a_act <= 1'b1;
    end else if (a_act) begin
      if (a_cnt == 0) a_act <= 1'b0;
      else            a_cnt <= a_cnt - 1;
    end
  end

  assign bus.aes_done = (a_act && a_cnt == 0 && !hang) || spur;
  assign bus.aes_dout = a_buf;

  // ---------------- monitor, sampled 2ns after the rising edge
  int           cyc = 0, n_rd = 0, n_start = 0, n_wr = 0, last_rd = -1;
  int           n_sep_bad = 0, n_din_bad = 0;
  logic [127:0] outq [$];

  always begin
    @(posedge clk);
    #2;
    cyc = cyc + 1;
    if (bus.in_rd_en) begin
      if (last_rd >= 0 && (cyc - last_rd) < MIN_SEP) n_sep_bad = n_sep_bad + 1;
      last_rd = cyc;
      n_rd = n_rd + 1;
    end
    if (bus.aes_start) begin
      n_start = n_start + 1;
      if (bus.aes_din !== rd_hold) n_din_bad = n_din_bad + 1;
    end
    if (bus.out_wr_en) begin
      n_wr = n_wr + 1;
      outq.push_back(bus.out_data);
    end
  end

  // ---------------- checking helpers
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // which: 0 = aes_start count, 1 = out_wr_en count
  task automatic wait_cnt(input string nm, input int which, input int target, input int budget);
    int i = 0;
    int v;
    v = (which == 0) ? n_start : n_wr;
    while (v < target && i < budget) begin
      tick(1);
      i = i + 1;
      v = (which == 0) ? n_start : n_wr;
    end
    chki(nm, (v >= target) ? 1 : 0, 1);
  endtask

  task automatic push_blk(input logic [127:0] d);
    mem[n_pushed] = d;
    n_pushed = n_pushed + 1;
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vec [10];

  initial begin
    vec[0] = '{128'h00112233_44556677_8899aabb_ccddeeff, 128'hffeeddcc_bbaa9988_77665544_33221100};
    vec[1] = '{128'h00000000_00000000_00000000_00000000, 128'hffffffff_ffffffff_ffffffff_ffffffff};
    vec[2] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 128'h00000000_00000000_00000000_00000000};
    vec[3] = '{128'h01234567_89abcdef_fedcba98_76543210, 128'hfedcba98_76543210_01234567_89abcdef};
    vec[4] = '{128'h5a5a5a5a_5a5a5a5a_5a5a5a5a_5a5a5a5a, 128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_a5a5a5a5};
    vec[5] = '{128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f, 128'hf0f0f0f0_f0f0f0f0_f0f0f0f0_f0f0f0f0};
    vec[6] = '{128'h13579bdf_02468ace_13579bdf_02468ace, 128'heca86420_fdb97531_eca86420_fdb97531};
    vec[7] = '{128'h80000000_00000000_00000000_00000001, 128'h7fffffff_ffffffff_ffffffff_fffffffe};
    vec[8] = '{128'hcafef00d_cafef00d_cafef00d_cafef00d, 128'h35010ff2_35010ff2_35010ff2_35010ff2};
    vec[9] = '{128'h12345678_9abcdef0_0fedcba9_87654321, 128'hedcba987_6543210f_f0123456_789abcde};

    // reset state
    tick(2);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in_rd_en", bus.in_rd_en, 1'b0);
    chk1("rst_aes_start", bus.aes_start, 1'b0);
    chk1("rst_out_wr_en", bus.out_wr_en, 1'b0);
    chk1("rst_err", err, 1'b0);
    chki("rst_blk_count", int'(blk_count), 0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_aes_din", bus.aes_din, '0);
    reset = 1'b1;
    tick(1);

    // single block
    push_blk(vec[0].din);
    enable = 1'b1;
    wait_cnt("single_wr_wait", 1, 1, 100);
    tick(5);
    chk("single_out_data", outq[0], vec[0].exp);
    chki("single_n_rd", n_rd, 1);
    chki("single_n_start", n_start, 1);
    chki("single_n_wr", n_wr, 1);
    chki("single_blk_count", int'(blk_count), 1);
    chk1("single_idle", busy, 1'b0);

    // back-to-back, table driven
    for (int i = 1; i <= 4; i++) push_blk(vec[i].din);
    wait_cnt("b2b_wr_wait", 1, 5, 300);
    tick(5);
    for (int i = 1; i <= 4; i++) chk($sformatf("b2b_out_data[%0d]", i), outq[i], vec[i].exp);
    chki("b2b_n_rd", n_rd, 5);
    chki("b2b_blk_count", int'(blk_count), 5);

    // output backpressure: full across 20 PUSH cycles
    push_blk(vec[5].din);
    wait_cnt("bp_start_wait", 0, 6, 100);
    out_full = 1'b1;
    tick(29);
    chki("bp_no_wr_during_full", n_wr, 5);
    chk1("bp_busy_stalled", busy, 1'b1);
    chk1("bp_wr_low_while_full", bus.out_wr_en, 1'b0);
    tick(1);
    out_full = 1'b0;
    #1;
    chk1("bp_wr_on_release", bus.out_wr_en, 1'b1);
    tick(1);
    chk1("bp_wr_single_pulse", bus.out_wr_en, 1'b0);
    tick(4);
    chki("bp_n_wr", n_wr, 6);
    chk("bp_out_data", outq[5], vec[5].exp);
    chki("bp_blk_count", int'(blk_count), 6);

    // reset in the middle of RUN; the AES model's late done becomes spurious
    push_blk(vec[6].din);
    wait_cnt("rst_run_start_wait", 0, 7, 100);
    tick(3);
    enable = 1'b0;
    reset  = 1'b0;
    #1;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_aes_start", bus.aes_start, 1'b0);
    chk1("mid_rst_out_wr_en", bus.out_wr_en, 1'b0);
    chk1("mid_rst_in_rd_en", bus.in_rd_en, 1'b0);
    chki("mid_rst_blk_count", int'(blk_count), 0);
    chk("mid_rst_aes_din", bus.aes_din, '0);
    chk("mid_rst_out_data", bus.out_data, '0);
    tick(2);
    reset = 1'b1;
    tick(12);
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    tick(5);
    chki("mid_rst_no_wr", n_wr, 6);
    chki("mid_rst_no_reread", n_rd, 7);
    chk1("mid_rst_idle", busy, 1'b0);

    // blk_count wrap
    force dut.blk_count_q = 16'hffff;
    tick(1);
    release dut.blk_count_q;
    enable = 1'b1;
    push_blk(vec[7].din);
    wait_cnt("wrap_wr_wait", 1, 7, 100);
    tick(5);
    chki("wrap_blk_count", int'(blk_count), 0);
    chk("wrap_out_data", outq[6], vec[7].exp);

`ifdef SEQ_WATCHDOG_EN
    // watchdog: AES never answers
    hang = 1'b1;
    push_blk(vec[8].din);
    wait_cnt("wd_start_wait", 0, 9, 100);
    tick(15);
    chk1("wd_err_before_timeout", err, 1'b0);
    tick(1);
    chk1("wd_err_set", err, 1'b1);
    chk1("wd_busy_in_err", busy, 1'b1);
    tick(3);
    chk1("wd_err_sticky", err, 1'b1);
    chki("wd_no_wr", n_wr, 7);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    hang    = 1'b0;
    chk1("wd_err_cleared", err, 1'b0);
    chk1("wd_back_to_idle", busy, 1'b0);
    chki("wd_blk_count_kept", int'(blk_count), 0);
    tick(2);
    push_blk(vec[9].din);
    wait_cnt("wd_recover_wr_wait", 1, 8, 100);
    tick(5);
    chk("wd_recover_out_data", outq[7], vec[9].exp);
    chki("wd_recover_blk_count", int'(blk_count), 1);
`else
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk1("no_wd_err_tied_low", err, 1'b0);
    chk1("no_wd_idle", busy, 1'b0);
`endif

    chki("rd_spacing_violations", n_sep_bad, 0);
    chki("aes_din_mismatches", n_din_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation ran past 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
